// File: rtl/core4_dbg_pkg.sv
// Shared types and defaults for the 4-core
// debug halt sequencer.
package core4_dbg_pkg;

  localparam int N_CORES_DEF     = 4;
  localparam int TIMEOUT_W_DEF   = 8;
  localparam int ACK_TIMEOUT_DEF = 200;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    HALTED,
    RELEASE
  } dbg_state_t;

endpackage

// File: rtl/core4_dbg_timeout_cnt.sv
// Saturating wait counter shared by the
// ack-wait and resume-wait phases.
module core4_dbg_timeout_cnt #(
  parameter int W     = 8,
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = '1;

  logic [W-1:0] cnt;

  // clear wins over inc; hold at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != TOP)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/core4_debug_halt_sequencer.sv
// Cross-core break coordinator: one core
// entering debug halts the whole group.
module core4_debug_halt_sequencer
  import core4_dbg_pkg::*;
#(
  parameter int N_CORES     = N_CORES_DEF,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [N_CORES-1:0] halt_mask,
  input  logic [N_CORES-1:0] debugack,
  input  logic               resume_req,
  output logic [N_CORES-1:0] debugreq,
  output logic               all_halted,
  output logic               busy,
  output logic [N_CORES-1:0] break_src,
  output logic               timeout_err
);

  if ((ACK_TIMEOUT < 1) ||
      (ACK_TIMEOUT >= (1 << TIMEOUT_W)))
  begin : g_width_chk
    $error("ACK_TIMEOUT does not fit TIMEOUT_W");
  end

  dbg_state_t         state;
  logic [N_CORES-1:0] act_mask;
  logic [N_CORES-1:0] acked;
  logic [N_CORES-1:0] hit;
  logic               all_ack;
  logic               none_ack;
  logic               trig;
  logic               resume_go;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               cnt_exp;

  // group status and counter control
  always_comb begin
    hit       = debugack & halt_mask;
    acked     = debugack & act_mask;
    all_ack   = (acked == act_mask);
    none_ack  = (acked == '0);
    trig      = enable && (state == IDLE) && (|hit);
    resume_go = enable && (state == HALTED)
                && resume_req;
    cnt_clr   = !enable || trig || resume_go;
    cnt_inc   = (state == WAIT_ACK)
                || (state == RELEASE);
  end

  core4_dbg_timeout_cnt #(
    .W     (TIMEOUT_W),
    .LIMIT (ACK_TIMEOUT)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .expired (cnt_exp)
  );

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      act_mask    <= '0;
      debugreq    <= '0;
      all_halted  <= 1'b0;
      busy        <= 1'b0;
      break_src   <= '0;
      timeout_err <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      debugreq   <= '0;
      all_halted <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            act_mask    <= halt_mask;
            break_src   <= hit;
            timeout_err <= 1'b0;
            debugreq    <= halt_mask & ~debugack;
            busy        <= 1'b1;
            state       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (all_ack) begin
            debugreq   <= '0;
            all_halted <= 1'b1;
            state      <= HALTED;
          end else if (cnt_exp) begin
            debugreq    <= '0;
            all_halted  <= 1'b0;
            timeout_err <= 1'b1;
            state       <= HALTED;
          end else begin
            debugreq <= act_mask & ~debugack;
          end
        end
        HALTED: begin
          debugreq <= '0;
          if (resume_req) begin
            all_halted <= 1'b0;
            state      <= RELEASE;
          end else begin
            all_halted <= all_ack;
          end
        end
        RELEASE: begin
          debugreq   <= '0;
          all_halted <= 1'b0;
          if (none_ack) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt_exp) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          debugreq   <= '0;
          all_halted <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core4_debug_halt_sequencer.sv
// Bench for the debug halt sequencer: vector
// table, corner sequences, random vs model.
module tb_core4_debug_halt_sequencer;

  localparam int TMO = 200;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] halt_mask;
  logic [3:0] debugack;
  logic       resume_req;
  logic [3:0] debugreq;
  logic       all_halted;
  logic       busy;
  logic [3:0] break_src;
  logic       timeout_err;

  int checks;
  int errors;

  core4_debug_halt_sequencer #(
    .N_CORES     (4),
    .TIMEOUT_W   (8),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .halt_mask   (halt_mask),
    .debugack    (debugack),
    .resume_req  (resume_req),
    .debugreq    (debugreq),
    .all_halted  (all_halted),
    .busy        (busy),
    .break_src   (break_src),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: group phase and elapsed wait
  localparam int P_IDLE = 0;
  localparam int P_ACK  = 1;
  localparam int P_HALT = 2;
  localparam int P_REL  = 3;

  int         m_phase;
  int         m_waited;
  logic [3:0] m_group;
  logic [3:0] m_req;
  logic       m_allh;
  logic       m_busy;
  logic [3:0] m_src;
  logic       m_terr;

  function automatic void model_reset();
    m_phase  = P_IDLE;
    m_waited = 0;
    m_group  = 4'h0;
    m_req    = 4'h0;
    m_allh   = 1'b0;
    m_busy   = 1'b0;
    m_src    = 4'h0;
    m_terr   = 1'b0;
  endfunction

  function automatic void model_step();
    logic [3:0] in_grp;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (!enable) begin
      m_phase = P_IDLE;
      m_req   = 4'h0;
      m_allh  = 1'b0;
      m_busy  = 1'b0;
      return;
    end
    in_grp = debugack & m_group;
    case (m_phase)
      P_IDLE: begin
        if ((debugack & halt_mask) != 4'h0) begin
          m_group  = halt_mask;
          m_src    = debugack & halt_mask;
          m_terr   = 1'b0;
          m_req    = halt_mask & ~debugack;
          m_busy   = 1'b1;
          m_waited = 0;
          m_phase  = P_ACK;
        end
      end
      P_ACK: begin
        if (in_grp == m_group) begin
          m_req   = 4'h0;
          m_allh  = 1'b1;
          m_phase = P_HALT;
        end else if (m_waited + 1 >= TMO) begin
          m_req   = 4'h0;
          m_allh  = 1'b0;
          m_terr  = 1'b1;
          m_phase = P_HALT;
        end else begin
          m_req    = m_group & ~debugack;
          m_waited = m_waited + 1;
        end
      end
      P_HALT: begin
        if (resume_req) begin
          m_allh   = 1'b0;
          m_waited = 0;
          m_phase  = P_REL;
        end else begin
          m_allh = (in_grp == m_group);
        end
      end
      default: begin
        if (in_grp == 4'h0) begin
          m_busy  = 1'b0;
          m_phase = P_IDLE;
        end else if (m_waited + 1 >= TMO) begin
          m_terr  = 1'b1;
          m_busy  = 1'b0;
          m_phase = P_IDLE;
        end else begin
          m_waited = m_waited + 1;
        end
      end
    endcase
  endfunction

  task automatic check_model(input string nm);
    checks++;
    if (debugreq !== m_req || all_halted !== m_allh ||
        busy !== m_busy || break_src !== m_src ||
        timeout_err !== m_terr) begin
      errors++;
      $display("FAIL %s: got req=%b allh=%b busy=%b src=%b terr=%b want req=%b allh=%b busy=%b src=%b terr=%b",
               nm, debugreq, all_halted, busy, break_src,
               timeout_err, m_req, m_allh, m_busy, m_src,
               m_terr);
    end
  endtask

  task automatic check_out(input string nm,
                           input logic [3:0] req,
                           input logic allh,
                           input logic bsy,
                           input logic [3:0] src,
                           input logic terr);
    checks++;
    if (debugreq !== req || all_halted !== allh ||
        busy !== bsy || break_src !== src ||
        timeout_err !== terr) begin
      errors++;
      $display("FAIL %s: got req=%b allh=%b busy=%b src=%b terr=%b want req=%b allh=%b busy=%b src=%b terr=%b",
               nm, debugreq, all_halted, busy, break_src,
               timeout_err, req, allh, bsy, src, terr);
    end
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    model_step();
    #1;
    check_model(nm);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [3:0] ack;
    logic       res;
    logic       en;
    logic [3:0] req;
    logic       busy;
    logic       allh;
    logic [3:0] src;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{4'hF, 4'h4, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 4'h4};
    tbl[2]  = '{4'hF, 4'h4, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 4'h4};
    tbl[3]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 4'h4};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 4'h4};
    tbl[5]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h4};
    tbl[6]  = '{4'hF, 4'h3, 1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 4'h3};
    tbl[7]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 4'h3};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 4'h3};
    tbl[9]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h3};
    tbl[10] = '{4'h0, 4'hF, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h3};
    tbl[11] = '{4'h0, 4'h5, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h3};

    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    enable     = 1'b0;
    halt_mask  = 4'h0;
    debugack   = 4'h0;
    resume_req = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    reset_n = 1'b1;
    enable  = 1'b1;

    // table-driven group halt and resume
    for (int i = 0; i < 12; i++) begin
      halt_mask  = tbl[i].mask;
      debugack   = tbl[i].ack;
      resume_req = tbl[i].res;
      enable     = tbl[i].en;
      @(posedge clk);
      model_step();
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].req,
                tbl[i].allh, tbl[i].busy, tbl[i].src,
                1'b0);
    end
    resume_req = 1'b0;

    // core1 never acks -> timeout into HALTED
    halt_mask = 4'h7;
    debugack  = 4'h4;
    tick("tmo_trig");
    check_out("tmo_trig_exp", 4'h3, 1'b0, 1'b1,
              4'h4, 1'b0);
    for (int i = 0; i < TMO - 1; i++) begin
      tick("tmo_wait");
    end
    check_out("tmo_edge_minus1", 4'h3, 1'b0, 1'b1,
              4'h4, 1'b0);
    tick("tmo_hit");
    check_out("tmo_hit_exp", 4'h0, 1'b0, 1'b1,
              4'h4, 1'b1);
    tick("tmo_halted");

    // resume then acks drop over 3 cycles
    resume_req = 1'b1;
    tick("rel_enter");
    resume_req = 1'b0;
    tick("rel_1");
    tick("rel_2");
    debugack = 4'h0;
    tick("rel_3");
    check_out("rel_idle_exp", 4'h0, 1'b0, 1'b0,
              4'h4, 1'b1);

    // enable drop in WAIT_ACK
    halt_mask = 4'hF;
    debugack  = 4'h1;
    tick("en_trig");
    check_out("en_trig_exp", 4'hE, 1'b0, 1'b1,
              4'h1, 1'b0);
    enable = 1'b0;
    tick("en_drop");
    check_out("en_drop_exp", 4'h0, 1'b0, 1'b0,
              4'h1, 1'b0);
    debugack = 4'hF;
    tick("en_off_ack");
    enable    = 1'b1;
    halt_mask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      debugack = 4'(i * 5 + 3);
      tick("mask0");
      check_out("mask0_exp", 4'h0, 1'b0, 1'b0,
                4'h1, 1'b0);
    end
    debugack = 4'h0;
    tick("settle");

    // async reset mid-WAIT_ACK
    halt_mask = 4'hF;
    debugack  = 4'h2;
    tick("rst_trig");
    check_out("rst_trig_exp", 4'hD, 1'b0, 1'b1,
              4'h2, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_out("async_rst", 4'h0, 1'b0, 1'b0,
              4'h0, 1'b0);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    debugack = 4'h0;

    // random traffic vs model
    for (int i = 0; i < 600; i++) begin
      halt_mask  = 4'($urandom_range(0, 15));
      debugack   = 4'($urandom_range(0, 15));
      resume_req = ($urandom_range(0, 9) == 0);
      enable     = ($urandom_range(0, 29) != 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
